// File: rtl/val2_shift_sequencer.sv
// rtl/val2_shift_sequencer.sv - Val2 operand sequencer with multi-cycle register-amount shifts
// Optional: VAL2_SEQ_EARLY_EXIT_EN ends a shift early once the accumulator can no longer change.
module val2_shift_sequencer #(
  parameter int STEP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        flush,
  input  logic        mem_cmd,
  input  logic        imm,
  input  logic        reg_shift,
  input  logic [11:0] shift_operand,
  input  logic [31:0] val_rm,
  input  logic [7:0]  rs_val,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] val_2
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] T_LSL = 2'd0;
  localparam logic [1:0] T_LSR = 2'd1;
  localparam logic [1:0] T_ASR = 2'd2;
  localparam logic [1:0] T_ROR = 2'd3;

  localparam logic [5:0] STEP_AMT = 6'(STEP);

  logic [1:0]  r_state;
  logic [31:0] r_val2;
  logic [31:0] r_acc;
  logic [5:0]  r_rem;
  logic [1:0]  r_type;

  logic [1:0]  w_type;
  logic [5:0]  w_r;
  logic        w_single;
  logic [31:0] w_single_val;
  logic [5:0]  w_step;
  logic [31:0] w_acc_next;
  logic [5:0]  w_rem_next;
  logic        w_early;

  // Shift amounts reach 32 only for LSL/LSR/ASR, where SV shift semantics give 0 / sign fill.
  function automatic logic [31:0] f_shift(input logic [31:0] v, input logic [1:0] t,
                                          input logic [5:0] s);
    logic [31:0] res;
    case (t)
      T_LSL:   res = v << s;
      T_LSR:   res = v >> s;
      T_ASR:   res = 32'($signed(v) >>> s);
      default: res = (v >> s) | (v << (6'd32 - s));
    endcase
    return res;
  endfunction

  assign w_type = shift_operand[6:5];
  assign w_r    = (w_type == T_ROR) ? {1'b0, rs_val[4:0]} :
                  (rs_val >= 8'd32) ? 6'd32 : rs_val[5:0];

  assign w_single = mem_cmd | imm | ~reg_shift | (w_r == 6'd0);

  always_comb begin
    w_single_val = val_rm;
    if (mem_cmd)
      w_single_val = {20'b0, shift_operand};
    else if (imm)
      w_single_val = f_shift({24'b0, shift_operand[7:0]}, T_ROR,
                             {1'b0, shift_operand[11:8], 1'b0});
    else if (!reg_shift)
      w_single_val = f_shift(val_rm, w_type, {1'b0, shift_operand[11:7]});
  end

  assign w_step     = (r_rem < STEP_AMT) ? r_rem : STEP_AMT;
  assign w_acc_next = f_shift(r_acc, r_type, w_step);
  assign w_rem_next = r_rem - w_step;

`ifdef VAL2_SEQ_EARLY_EXIT_EN
  assign w_early = (((r_type == T_LSL) || (r_type == T_LSR)) && (r_acc == 32'd0)) ||
                   ((r_type == T_ASR) && ((r_acc == 32'd0) || (&r_acc)));
`else
  assign w_early = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_val2  <= 32'd0;
      r_acc   <= 32'd0;
      r_rem   <= 6'd0;
      r_type  <= T_LSL;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_SHIFT: begin
          if (w_early) begin
            r_val2  <= r_acc;
            r_state <= S_DONE;
          end else begin
            r_acc <= w_acc_next;
            r_rem <= w_rem_next;
            if (w_rem_next == 6'd0) begin
              r_val2  <= w_acc_next;
              r_state <= S_DONE;
            end
          end
        end
        default: begin
          // IDLE and DONE both accept a new request.
          if (req) begin
            if (w_single) begin
              r_val2  <= w_single_val;
              r_state <= S_DONE;
            end else begin
              r_acc   <= val_rm;
              r_rem   <= w_r;
              r_type  <= w_type;
              r_state <= S_SHIFT;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign ready = (r_state != S_SHIFT);
  assign busy  = (r_state == S_SHIFT);
  assign done  = (r_state == S_DONE);
  assign val_2 = r_val2;

endmodule

// File: tb/tb_val2_shift_sequencer.sv
// tb/tb_val2_shift_sequencer.sv - randomized self-checking bench for val2_shift_sequencer
module tb_val2_shift_sequencer;

  localparam int STEP = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        flush;
  logic        mem_cmd;
  logic        imm;
  logic        reg_shift;
  logic [11:0] shift_operand;
  logic [31:0] val_rm;
  logic [7:0]  rs_val;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] val_2;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last_exp = 32'd0;

  val2_shift_sequencer #(.STEP(STEP)) dut (
    .clk(clk), .rst(rst), .req(req), .flush(flush), .mem_cmd(mem_cmd), .imm(imm),
    .reg_shift(reg_shift), .shift_operand(shift_operand), .val_rm(val_rm), .rs_val(rs_val),
    .ready(ready), .busy(busy), .done(done), .val_2(val_2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: one bit position per loop iteration, straight from the shift definitions.
  function automatic logic [31:0] m_shift(input logic [31:0] v, input int t, input int n);
    logic [31:0] x = v;
    for (int i = 0; i < n; i++) begin
      case (t)
        0: x = {x[30:0], 1'b0};
        1: x = {1'b0, x[31:1]};
        2: x = {x[31], x[31:1]};
        default: x = {x[0], x[31:1]};
      endcase
    end
    return x;
  endfunction

  function automatic logic [31:0] m_val2(input logic m, input logic i, input logic rsh,
                                         input logic [11:0] op, input logic [31:0] rm,
                                         input logic [7:0] rs);
    int t = int'(op[6:5]);
    if (m) return {20'b0, op};
    if (i) return m_shift({24'b0, op[7:0]}, 3, 2 * int'(op[11:8]));
    if (!rsh) return m_shift(rm, t, int'(op[11:7]));
    if (t == 3) return m_shift(rm, 3, int'(rs) % 32);
    return m_shift(rm, t, int'(rs));
  endfunction

  function automatic int m_lat(input logic m, input logic i, input logic rsh,
                               input logic [11:0] op, input logic [7:0] rs);
    int r;
    if (m || i || !rsh) return 1;
    r = (op[6:5] == 2'd3) ? int'(rs) % 32 : ((int'(rs) > 32) ? 32 : int'(rs));
    if (r == 0) return 1;
    return 1 + (r + STEP - 1) / STEP;
  endfunction

  task automatic scramble();
    mem_cmd       = 1'($urandom);
    imm           = 1'($urandom);
    reg_shift     = 1'($urandom);
    shift_operand = 12'($urandom);
    val_rm        = $urandom;
    rs_val        = 8'($urandom);
  endtask

  // Called at a negedge; the request is accepted at the following posedge (cycle N).
  task automatic do_op(input string tag, input logic m, input logic i, input logic rsh,
                       input logic [11:0] op, input logic [31:0] rm, input logic [7:0] rs,
                       input bit poke);
    logic [31:0] exp;
    int lat, got, nbusy;
    exp = m_val2(m, i, rsh, op, rm, rs);
    lat = m_lat(m, i, rsh, op, rs);
    mem_cmd = m; imm = i; reg_shift = rsh; shift_operand = op; val_rm = rm; rs_val = rs;
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    scramble();
    got = 0;
    nbusy = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (poke && k == 2) req = 1'b0;
      if (busy) nbusy++;
      if (done) begin
        got = k;
        break;
      end
      if (poke && k == 1) begin
        mem_cmd = 1'b1;
        req = 1'b1;
      end
    end
    check({tag, "_lat"}, 32'(got), 32'(lat));
    check({tag, "_busy"}, 32'(nbusy), 32'(lat - 1));
    check({tag, "_val2"}, val_2, exp);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    last_exp = exp;
  endtask

  initial begin
    logic [7:0] rs_pick [10] = '{8'd0, 8'd1, 8'd7, 8'd8, 8'd9, 8'd31, 8'd32, 8'd33, 8'd255, 8'd40};
    rst = 1'b0; req = 1'b0; flush = 1'b0;
    mem_cmd = 1'b0; imm = 1'b0; reg_shift = 1'b0;
    shift_operand = 12'd0; val_rm = 32'd0; rs_val = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_val2", val_2, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    do_op("imm", 1'b0, 1'b1, 1'b0, 12'h2FF, 32'h0, 8'h0, 1'b0);
    check("imm_const", last_exp, 32'hF000000F);
    do_op("memwin", 1'b1, 1'b1, 1'b0, 12'hABC, 32'h5, 8'h0, 1'b0);
    check("mem_const", last_exp, 32'h00000ABC);
    do_op("lsl20", 1'b0, 1'b0, 1'b1, 12'h000, 32'h1, 8'd20, 1'b0);
    do_op("asr40", 1'b0, 1'b0, 1'b1, 12'h040, 32'h80000000, 8'd40, 1'b0);
    do_op("ror36", 1'b0, 1'b0, 1'b1, 12'h060, 32'h12345678, 8'd36, 1'b0);
    check("ror_const", last_exp, 32'h81234567);
    do_op("lsr0", 1'b0, 1'b0, 1'b1, 12'h020, 32'hDEADBEEF, 8'd0, 1'b0);
    do_op("poke", 1'b0, 1'b0, 1'b1, 12'h020, 32'hF0F0F0F0, 8'd30, 1'b1);

    // Flush on the second shift cycle of a 32-bit LSL.
    mem_cmd = 1'b0; imm = 1'b0; reg_shift = 1'b1; shift_operand = 12'h000;
    val_rm = 32'h5; rs_val = 8'd32; req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_ready", 32'(ready), 32'd1);
    check("flush_val2", val_2, last_exp);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("flush_nodone", 32'(done), 32'd0);
    end

    // Flush with a simultaneous request drops the request.
    mem_cmd = 1'b1; shift_operand = 12'h123; req = 1'b1; flush = 1'b1;
    @(negedge clk);
    req = 1'b0; flush = 1'b0;
    check("flushreq_done", 32'(done), 32'd0);
    check("flushreq_val2", val_2, last_exp);

    // Reset in the middle of a shift.
    mem_cmd = 1'b0; reg_shift = 1'b1; shift_operand = 12'h040;
    val_rm = 32'h80000000; rs_val = 8'd32; req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    check("rstmid_ready", 32'(ready), 32'd1);
    check("rstmid_val2", val_2, 32'd0);
    rst = 1'b1;
    last_exp = 32'd0;
    @(negedge clk);
    check("rstmid_nodone", 32'(done), 32'd0);

    for (int n = 0; n < 60; n++) begin
      int kind = int'($urandom_range(0, 7));
      logic [11:0] op = 12'($urandom);
      logic [7:0] rs = (($urandom & 1) != 0) ? rs_pick[$urandom_range(0, 9)] : 8'($urandom);
      do_op("rand", kind == 0, kind == 1, kind >= 5, op, $urandom, rs, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
